// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight GPR writers and the HI/LO busy counter; drives the D-stage stall and forward selects.
// Defining HAZ_SCOREBOARD_PERF_EN adds the stall_cnt / md_stall_cnt performance counters.
module hazard_scoreboard #(
    parameter int NSTAGE  = 3,
    parameter int TW      = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int SW     = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic          d_we,
    input  logic [4:0]    d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic [1:0]    d_md_op,
    input  logic          d_hilo_use,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
`ifdef HAZ_SCOREBOARD_PERF_EN
    output logic [31:0]   stall_cnt,
    output logic [31:0]   md_stall_cnt,
`endif
    output logic          md_busy
);

    localparam int BW = $clog2(DIV_LAT + 1);

    logic [NSTAGE-1:0] v_q, v_d;
    logic [4:0]        addr_q [NSTAGE];
    logic [4:0]        addr_d [NSTAGE];
    logic [TW-1:0]     tnew_q [NSTAGE];
    logic [TW-1:0]     tnew_d [NSTAGE];
    logic [BW-1:0]     bcnt_q, bcnt_d;

    logic          rs_hit, rt_hit;
    logic [SW-1:0] rs_pos, rt_pos;
    logic [TW-1:0] rs_tnew, rt_tnew;
    logic          rs_term, rt_term, hilo_term;

    // Scan oldest to youngest so the youngest match overwrites and shadows older writes.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_pos  = '0;
        rt_pos  = '0;
        rs_tnew = '0;
        rt_tnew = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (v_q[i] && (addr_q[i] == d_rs) && (d_rs != 5'd0)) begin
                rs_hit  = 1'b1;
                rs_pos  = SW'(i + 1);
                rs_tnew = tnew_q[i];
            end
            if (v_q[i] && (addr_q[i] == d_rt) && (d_rt != 5'd0)) begin
                rt_hit  = 1'b1;
                rt_pos  = SW'(i + 1);
                rt_tnew = tnew_q[i];
            end
        end
        rs_term    = rs_hit && (rs_tnew > d_rs_tuse);
        rt_term    = rt_hit && (rt_tnew > d_rt_tuse);
        hilo_term  = d_hilo_use && (bcnt_q != '0);
        stall      = rs_term || rt_term || hilo_term;
        fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_pos : '0;
        fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_pos : '0;
        md_busy    = (bcnt_q != '0);
    end

    always_comb begin
        v_d = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            addr_d[i] = '0;
            tnew_d[i] = '0;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            v_d[i]    = v_q[i-1];
            addr_d[i] = addr_q[i-1];
            tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
        end
        v_d[0]    = !stall && d_we && (d_dst != 5'd0);
        addr_d[0] = stall ? '0 : d_dst;
        tnew_d[0] = stall ? '0 : d_tnew;
        if (flush) begin
            v_d = '0;
        end

        // An issued multiply/divide keeps counting through a flush; only a fresh issue reloads.
        bcnt_d = (bcnt_q == '0) ? '0 : bcnt_q - BW'(1);
        if (!stall && !flush) begin
            if (d_md_op == 2'b01) begin
                bcnt_d = BW'(MUL_LAT);
            end else if (d_md_op == 2'b10) begin
                bcnt_d = BW'(DIV_LAT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            bcnt_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                addr_q[i] <= '0;
                tnew_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            bcnt_q <= bcnt_d;
            for (int i = 0; i < NSTAGE; i++) begin
                addr_q[i] <= addr_d[i];
                tnew_q[i] <= tnew_d[i];
            end
        end
    end

`ifdef HAZ_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
        md_stall_cnt_d = (hilo_term && !rs_term && !rt_term) ? md_stall_cnt_q + 32'd1
                                                             : md_stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`endif

`ifndef SYNTHESIS
    // A writer must have produced its result before it falls off the last tracked stage.
    a_drop_ready: assert property (@(posedge clk) disable iff (reset)
        !(v_q[NSTAGE-1] && (tnew_q[NSTAGE-1] != '0)));
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset-mid-divide sequence, random run against a history model.
module tb_hazard_scoreboard;

    localparam int NSTAGE  = 3;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [2:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_we, d_hilo_use;
    logic [1:0] d_md_op;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZ_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    hazard_scoreboard #(.NSTAGE(NSTAGE), .TW(3), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_we(d_we), .d_dst(d_dst), .d_tnew(d_tnew), .d_md_op(d_md_op), .d_hilo_use(d_hilo_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
`ifdef HAZ_SCOREBOARD_PERF_EN
        .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
        .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic [4:0] rs;
        logic [2:0] rs_tuse;
        logic [4:0] rt;
        logic [2:0] rt_tuse;
        logic       we;
        logic [4:0] dst;
        logic [2:0] tnew;
        logic [1:0] md_op;
        logic       hilo;
        logic       e_stall;
        logic [1:0] e_rs_sel;
        logic [1:0] e_rt_sel;
        logic       e_busy;
    } vec_t;

    typedef struct {
        bit         v;
        logic [4:0] a;
        int         t;
    } wr_t;

    vec_t vecs[$];
    wr_t  hist[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic fl, input logic [4:0] rs, input logic [2:0] rsu,
                                input logic [4:0] rt, input logic [2:0] rtu, input logic we,
                                input logic [4:0] dst, input logic [2:0] tn, input logic [1:0] md,
                                input logic hl, input logic es, input logic [1:0] ers,
                                input logic [1:0] ert, input logic eb);
        vec_t v;
        v.flush = fl; v.rs = rs; v.rs_tuse = rsu; v.rt = rt; v.rt_tuse = rtu;
        v.we = we; v.dst = dst; v.tnew = tn; v.md_op = md; v.hilo = hl;
        v.e_stall = es; v.e_rs_sel = ers; v.e_rt_sel = ert; v.e_busy = eb;
        return v;
    endfunction

    task automatic add(input logic fl, input logic [4:0] rs, input logic [2:0] rsu,
                       input logic [4:0] rt, input logic [2:0] rtu, input logic we,
                       input logic [4:0] dst, input logic [2:0] tn, input logic [1:0] md,
                       input logic hl, input logic es, input logic [1:0] ers,
                       input logic [1:0] ert, input logic eb);
        vecs.push_back(mk(fl, rs, rsu, rt, rtu, we, dst, tn, md, hl, es, ers, ert, eb));
    endtask

    task automatic drive(input vec_t v);
        flush = v.flush; d_rs = v.rs; d_rs_tuse = v.rs_tuse; d_rt = v.rt; d_rt_tuse = v.rt_tuse;
        d_we = v.we; d_dst = v.dst; d_tnew = v.tnew; d_md_op = v.md_op; d_hilo_use = v.hilo;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Youngest accepted writer for register r; its ready countdown is its issue T_new minus its age.
    function automatic void lookup(input logic [4:0] r, input int tuse, output bit st, output int sel);
        int eff;
        st = 1'b0;
        sel = 0;
        if (r == 5'd0) return;
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].v && hist[k].a == r) begin
                eff = hist[k].t - k;
                if (eff < 0) eff = 0;
                st = (eff > tuse);
                sel = (eff == 0) ? k + 1 : 0;
                return;
            end
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        bit   s_rs, s_rt, busy, e_st;
        int   sel_rs, sel_rt, cyc, busy_end;
        longint exp_sc, exp_mc;

        // Producer distance
        add(0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // $0 never tracked, never stalls
        add(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Youngest wins
        add(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // mult: 5 busy cycles; a div attempted while busy is stalled and does not reload
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < MUL_LAT; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, (i == 2) ? 2'd2 : 2'd0, 1, 1, 0, 0, 1);
        // div: 10 busy cycles
        add(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        for (int i = 0; i < DIV_LAT; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Flush drops pending writer but not the divide in progress
        add(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DIV_LAT - 3; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_stall", stall, 0);
        chk("reset_rs_sel", fwd_rs_sel, 0);
        chk("reset_rt_sel", fwd_rt_sel, 0);
        chk("reset_md_busy", md_busy, 0);
`ifdef HAZ_SCOREBOARD_PERF_EN
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_md_stall_cnt", md_stall_cnt, 0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_rs_sel", i), fwd_rs_sel, vecs[i].e_rs_sel);
            chk($sformatf("vec%0d_rt_sel", i), fwd_rt_sel, vecs[i].e_rt_sel);
            chk($sformatf("vec%0d_md_busy", i), md_busy, vecs[i].e_busy);
            @(posedge clk);
            #1;
        end
`ifdef HAZ_SCOREBOARD_PERF_EN
        // Table stalls: 1 + 1 (youngest) + 5 + 10 + 7, of which 22 are HI/LO only
        chk("table_stall_cnt", stall_cnt, 24);
        chk("table_md_stall_cnt", md_stall_cnt, 22);
`endif

        // Reset in the middle of a divide, with a pending r8 writer
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1 drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1 drive(mk(0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 drive(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        reset = 1'b1;
        @(negedge clk);
        chk("middiv_busy_before", md_busy, 1);
        chk("middiv_stall_before", stall, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("middiv_busy_after", md_busy, 0);
        chk("middiv_stall_after", stall, 0);
        chk("middiv_rs_sel_after", fwd_rs_sel, 0);
        chk("middiv_rt_sel_after", fwd_rt_sel, 0);
`ifdef HAZ_SCOREBOARD_PERF_EN
        chk("middiv_stall_cnt", stall_cnt, 0);
`endif

        // Random traffic against the history model
        do_reset();
        hist.delete();
        cyc = 0;
        busy_end = -1;
        exp_sc = 0;
        exp_mc = 0;
        for (int n = 0; n < 1500; n++) begin
            r.flush   = ($urandom_range(0, 15) == 0);
            r.rs      = 5'($urandom_range(0, 3));
            r.rt      = 5'($urandom_range(0, 3));
            r.rs_tuse = 3'($urandom_range(0, 3));
            r.rt_tuse = 3'($urandom_range(0, 3));
            r.we      = 1'($urandom_range(0, 1));
            r.dst     = 5'($urandom_range(0, 3));
            r.tnew    = 3'($urandom_range(0, NSTAGE - 1));
            r.md_op   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            r.hilo    = (r.md_op != 2'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(r);

            lookup(r.rs, int'(r.rs_tuse), s_rs, sel_rs);
            lookup(r.rt, int'(r.rt_tuse), s_rt, sel_rt);
            busy = (cyc <= busy_end);
            e_st = s_rs || s_rt || (r.hilo && busy);
            if (e_st) exp_sc++;
            if (r.hilo && busy && !s_rs && !s_rt) exp_mc++;

            @(negedge clk);
            chk("rand_stall", stall, e_st);
            chk("rand_rs_sel", fwd_rs_sel, sel_rs);
            chk("rand_rt_sel", fwd_rt_sel, sel_rt);
            chk("rand_md_busy", md_busy, busy);

            hist.push_front('{v: (!e_st && r.we && r.dst != 5'd0), a: r.dst, t: int'(r.tnew)});
            if (hist.size() > NSTAGE) void'(hist.pop_back());
            if (r.flush) begin
                for (int k = 0; k < hist.size(); k++) hist[k].v = 1'b0;
            end
            if (!e_st && !r.flush && r.md_op == 2'd1) busy_end = cyc + MUL_LAT;
            if (!e_st && !r.flush && r.md_op == 2'd2) busy_end = cyc + DIV_LAT;
            cyc++;
            @(posedge clk);
            #1;
        end
`ifdef HAZ_SCOREBOARD_PERF_EN
        chk("rand_stall_cnt", stall_cnt, exp_sc);
        chk("rand_md_stall_cnt", md_stall_cnt, exp_mc);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-depth T_use/T_new stall logic that sits beside the decoder's hazard outputs.
- Tracks writers in flight across NSTAGE post-decode stages with per-entry T_new countdowns.
- Tracks a multi-cycle HI/LO unit busy counter.
- Each cycle, produces the D-stage stall and the youngest-ready forward selects for rs/rt.

Parameters:
NSTAGE, 3, producer stages after D (entry 0 = E, entry 1 = M, ...); range 2..8
TW, 3, width of T_use/T_new fields
MUL_LAT, 5, HI/LO busy cycles loaded on mult/multu issue
DIV_LAT, 10, HI/LO busy cycles loaded on div/divu issue
(localparam SW = $clog2(NSTAGE+1), width of forward selects)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  exception/eret flush; clears in-flight writers
d_rs  in  5  D-stage rs address
d_rt  in  5  D-stage rt address
d_rs_tuse  in  TW  rs T_use
d_rt_tuse  in  TW  rt T_use
d_we  in  1  D instruction writes the GPR file
d_dst  in  5  D instruction destination
d_tnew  in  TW  D instruction T_new on entering E
d_md_op  in  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as 00)
d_hilo_use  in  1  D is md/mf/mt; caller includes md ops
stall  out  1  freeze PC/D, bubble into E
fwd_rs_sel  out  SW  0 = no forward; k = entry k-1
fwd_rt_sel  out  SW  same for rt
md_busy  out  1  HI/LO busy counter nonzero

Behaviour:
- State:
  - entry[0..NSTAGE-1] = {v, addr[4:0], tnew[TW-1:0]}.
  - bcnt = HI/LO busy counter, width clog2(DIV_LAT+1).
- Reset: all v=0, addr=0, tnew=0, bcnt=0.
  - After reset: stall=0, fwd_*_sel=0, md_busy=0.
- Combinational, from current state and D inputs:
  - match_rs[i] = v[i] & (addr[i]==d_rs) & (d_rs!=0); same for rt.
  - Stall term for rs = youngest matching entry (lowest i) has tnew > d_rs_tuse.
  - Older matches are ignored, because the youngest write shadows them. Same rule for rt.
  - stall = rs_term | rt_term | (d_hilo_use & bcnt!=0).
  - fwd_rs_sel = i+1 when the youngest match i has tnew==0; otherwise 0. Same for rt.
  - Forward selects are valid even while stall=1; the consumer ignores them then.
- Sequential, on posedge clk, in priority order:
  - reset > flush > normal.
  - Shift: entry[i] <= entry[i-1] for i ≥ 1, with tnew decremented saturating at 0. entry[NSTAGE-1] is dropped.
  - entry[0]:
    - stall=1: bubble (v=0).
    - stall=0: {d_we & d_dst!=0, d_dst, d_tnew}.
  - flush=1: every entry v<=0; bcnt is NOT cleared, because an issued md completes.
  - bcnt load:
    - MUL_LAT when stall=0 & flush=0 & d_md_op==01.
    - DIV_LAT for 10.
    - Load overrides decrement.
  - bcnt otherwise decrements to 0 and holds.
- Boundaries:
  - d_rs/d_rt == 0: never stall, select 0.
  - tnew at 0: stays 0.
  - An md op while busy stalls via d_hilo_use and cannot reload.
  - Entry leaving NSTAGE-1 with tnew>0 is a caller error; assert in simulation.
  - Reset mid-division clears bcnt immediately.
- Latency: stall and selects are combinational, 0 cycles. State updates 1 cycle later.

Optional Feature:
- Macro: HAZ_SCOREBOARD_PERF_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and md_stall_cnt[31:0], both 0 on reset.
  - stall_cnt increments every cycle stall=1.
  - md_stall_cnt increments when the stall is caused only by the HI/LO term.
  - Both counters wrap at 2^32.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Producer-distance stall, defaults:
  - Stimulus: cycle 1 D = {d_we=1, d_dst=8, d_tnew=1}; cycle 2 D = {d_rs=8, d_rs_tuse=0}.
  - Cycle 2 response: stall=1, fwd_rs_sel=0.
  - Cycle 3 response: stall=0, fwd_rs_sel=2.
- $0 dependency:
  - Stimulus: producer writes dst=0 with tnew=2; consumer d_rs=0, tuse=0.
  - Response: stall=0, fwd_rs_sel=0 on every cycle.
- Youngest-wins:
  - Stimulus: r9 in entry0 (tnew 0) and entry1 (tnew 0); d_rt=9.
  - Response: fwd_rt_sel=1.
  - Further: with entry0 tnew=2 and d_rt_tuse=1, stall=1 even though entry1 is ready.
- HI/LO latency:
  - Stimulus: mult issued (d_md_op=01), next D has d_hilo_use=1.
  - Response: stall=1 for exactly 5 cycles, md_busy deasserts the same cycle stall drops.
  - Repeat with div: exactly 10 stall cycles.
- Flush:
  - Stimulus: pending r8 with tnew 2; pulse flush.
  - Response: the following cycle a consumer of r8 sees stall=0, fwd_rs_sel=0.
  - A div issued before the flush still holds md_busy for its remaining count.
- Reset mid-div:
  - Stimulus: assert reset at bcnt=6.
  - Response: next cycle md_busy=0, stall=0, all selects 0.
  - With HAZ_SCOREBOARD_PERF_EN: stall_cnt=0.
